// File: rtl/booth_pp_accumulator_if.sv
// Handshake bundle for the Booth partial-product accumulator: PP bank input,
// input/output valid-ready pairs, accumulated product and busy status.
interface booth_pp_accumulator_if #(
    parameter int PP_W = 32
);
    logic [PP_W-1:0] PP1;
    logic [PP_W-1:0] PP2;
    logic [PP_W-1:0] PP3;
    logic [PP_W-1:0] PP4;
    logic [PP_W-1:0] PP5;
    logic [PP_W-1:0] PP6;
    logic [PP_W-1:0] PP7;
    logic [PP_W-1:0] PP8;
    logic            in_valid;
    logic            in_ready;
    logic [PP_W-1:0] product;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    modport master (
        output PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8,
        output in_valid, out_ready,
        input  in_ready, product, out_valid, busy
    );

    modport slave (
        input  PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8,
        input  in_valid, out_ready,
        output in_ready, product, out_valid, busy
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator: captures eight Booth partial products in one handshake,
// sums them one per clock (modulo 2^PP_W) and presents the result under valid/ready.
module booth_pp_accumulator #(
    parameter int PP_W = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    booth_pp_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PP_W-1:0] acc_q, acc_d;
    logic [2:0]      idx_q, idx_d;
    logic [PP_W-1:0] ppBank_q [8];
    logic [PP_W-1:0] ppBank_d [8];
    logic [PP_W-1:0] ppIn [8];
    logic            inFire;
    logic            outFire;

    assign ppIn[0] = bus.PP1;
    assign ppIn[1] = bus.PP2;
    assign ppIn[2] = bus.PP3;
    assign ppIn[3] = bus.PP4;
    assign ppIn[4] = bus.PP5;
    assign ppIn[5] = bus.PP6;
    assign ppIn[6] = bus.PP7;
    assign ppIn[7] = bus.PP8;

    assign inFire  = bus.in_valid  && (state_q == IDLE);
    assign outFire = bus.out_ready && (state_q == DONE);

    // idx parks at 7 on the final add so it never wraps inside a transaction.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        ppBank_d = ppBank_q;
        case (state_q)
            IDLE: begin
                if (inFire) begin
                    ppBank_d = ppIn;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ppBank_q[idx_q];
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                if (outFire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                ppBank_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            ppBank_q <= ppBank_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = acc_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator: directed vectors, reset cases and
// randomized PP sets compared against a plain-arithmetic sum model.
module tb_booth_pp_accumulator;

    localparam int PP_W = 32;

    typedef logic [7:0][PP_W-1:0] ppSet_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_pp_accumulator_if #(.PP_W(PP_W)) busIf ();

    booth_pp_accumulator #(.PP_W(PP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // Reference: the product is simply the sum of all eight PPs, reduced modulo 2^PP_W.
    function automatic logic [PP_W-1:0] modelSum(input ppSet_t pp);
        logic [63:0] total;
        total = 64'd0;
        for (int i = 0; i < 8; i++) begin
            total = total + {32'd0, pp[i]};
        end
        return total[PP_W-1:0];
    endfunction

    function automatic ppSet_t randomSet();
        ppSet_t pp;
        for (int i = 0; i < 8; i++) begin
            pp[i] = $urandom;
        end
        return pp;
    endfunction

    task automatic checkOutput(input string tag, input logic [PP_W-1:0] observed,
                               input logic [PP_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic driveSet(input ppSet_t pp);
        busIf.PP1 = pp[0];
        busIf.PP2 = pp[1];
        busIf.PP3 = pp[2];
        busIf.PP4 = pp[3];
        busIf.PP5 = pp[4];
        busIf.PP6 = pp[5];
        busIf.PP7 = pp[6];
        busIf.PP8 = pp[7];
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: handshake, 8-cycle accumulate, optional stall, drain.
    // While busy, in_valid/out_ready/PPs are driven with noise that must be ignored.
    task automatic applyStimulus(input string tag, input ppSet_t pp, input int holdCycles);
        logic [PP_W-1:0] expected;
        int              cycles;
        bit              seen;
        expected = modelSum(pp);

        checkFlag({tag, " in_ready before handshake"}, busIf.in_ready, 1'b1);
        driveSet(pp);
        busIf.in_valid  = 1'b1;
        busIf.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            driveSet(randomSet());
            busIf.in_valid  = 1'($urandom_range(0, 1));
            busIf.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (busIf.out_valid === 1'b1) begin
                seen = 1'b1;
            end else if (cycles == 4) begin
                checkFlag({tag, " in_ready in ACCUM"}, busIf.in_ready, 1'b0);
            end
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;

        checkOutput({tag, " latency"}, 32'(cycles), 32'd8);
        if (!seen) begin
            pulseReset();
            return;
        end
        checkOutput({tag, " product"}, busIf.product, expected);
        checkFlag({tag, " busy in DONE"}, busIf.busy, 1'b1);

        for (int h = 0; h < holdCycles; h++) begin
            busIf.in_valid = ((h % 2) == 0);
            driveSet(randomSet());
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " stall product"}, busIf.product, expected);
            checkFlag({tag, " stall out_valid"}, busIf.out_valid, 1'b1);
            checkFlag({tag, " stall in_ready"}, busIf.in_ready, 1'b0);
        end
        busIf.in_valid = 1'b0;

        busIf.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        busIf.out_ready = 1'b0;
        checkFlag({tag, " out_valid after drain"}, busIf.out_valid, 1'b0);
        checkFlag({tag, " in_ready after drain"}, busIf.in_ready, 1'b1);
        checkFlag({tag, " busy after drain"}, busIf.busy, 1'b0);
        checkOutput({tag, " product held in IDLE"}, busIf.product, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ppSet_t pp;

        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        driveSet('0);

        // Reset values while rst_n is low and in the first cycle after release.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset product", busIf.product, '0);
        checkFlag("reset out_valid", busIf.out_valid, 1'b0);
        checkFlag("reset busy", busIf.busy, 1'b0);
        checkFlag("reset in_ready", busIf.in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // M=3, Q=5
        pp = '0;
        pp[0] = 32'h0000_0003;
        pp[1] = 32'h0000_000C;
        applyStimulus("m3q5", pp, 0);

        // M=Q=0xFFFF
        pp = '0;
        pp[0] = 32'h0000_0001;
        applyStimulus("mffff", pp, 1);

        // M=0x7FFF, Q=0x8000
        pp = '0;
        pp[7] = 32'hC000_8000;
        applyStimulus("m7fff", pp, 0);

        // Carry-out discarded
        pp = '1;
        applyStimulus("allones", pp, 0);

        // Long stall with in_valid pulsing; no second result afterwards.
        pp = randomSet();
        applyStimulus("stall20", pp, 20);
        @(posedge clk);
        @(negedge clk);
        checkFlag("stall20 no extra result", busIf.out_valid, 1'b0);
        checkFlag("stall20 still idle", busIf.busy, 1'b0);

        // Reset 4 clocks into ACCUM discards the transaction.
        pp = randomSet();
        driveSet(pp);
        busIf.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset product", busIf.product, '0);
        checkFlag("midreset out_valid", busIf.out_valid, 1'b0);
        checkFlag("midreset busy", busIf.busy, 1'b0);
        checkFlag("midreset in_ready", busIf.in_ready, 1'b1);
        busIf.out_ready = 1'b1;
        @(negedge clk);
        busIf.out_ready = 1'b0;
        rst_n = 1'b1;
        pp = '0;
        pp[0] = 32'h0000_0003;
        pp[1] = 32'h0000_000C;
        applyStimulus("postreset m3q5", pp, 0);

        // Randomized sets with random stall lengths.
        for (int n = 0; n < 8; n++) begin
            applyStimulus("random", randomSet(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
